// File: rtl/swm_pkg.sv
// Shared types for the serial word matcher: controller state encoding.
package swm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } swm_state_t;

endpackage

// File: rtl/comparator_generic.sv
// Parameterised equality comparator between two WIDTH-bit words.
module comparator_generic #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] first_word,
  input  logic [WIDTH-1:0] second_word,
  output logic             equal
);

  assign equal = (first_word == second_word);

endmodule

// File: rtl/serial_word_matcher.sv
// Deserialises a valid-qualified MSB-first bit stream into WIDTH-bit words and
// compares each word with a programmed pattern, in framed or sliding-window mode.
module serial_word_matcher
  import swm_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_pattern,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             mode_sliding,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             count_clr,
  output logic             match_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic             armed
);

  localparam int FW = $clog2(WIDTH + 1);

  swm_state_t       state;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [FW-1:0]    fill_cnt;
  logic             accept;
  logic             fill_done;
  logic             cmp_evt;
  logic             word_eq;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // A load on the same cycle as a valid bit drops the bit.
  always_comb begin
    accept    = bit_valid && (state != S_IDLE) && !load_pattern;
    shreg_nxt = accept ? {shreg[WIDTH-2:0], bit_in} : shreg;
    fill_done = (fill_cnt == FW'(WIDTH - 1));
    cmp_evt   = 1'b0;
    if (accept) begin
      case (state)
        S_FILL:  cmp_evt = fill_done;
        S_RUN:   cmp_evt = mode_sliding;
        default: cmp_evt = 1'b0;
      endcase
    end
  end

  comparator_generic #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .first_word (shreg_nxt),
    .second_word(pattern),
    .equal      (word_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pattern     <= '0;
      shreg       <= '0;
      fill_cnt    <= '0;
      armed       <= 1'b0;
      match_valid <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match_valid <= cmp_evt;
      if (cmp_evt) match <= word_eq;

      if (load_pattern) begin
        pattern  <= pattern_in;
        shreg    <= '0;
        fill_cnt <= '0;
        state    <= S_FILL;
        armed    <= 1'b1;
      end else if (accept) begin
        shreg <= shreg_nxt;
        case (state)
          S_FILL: begin
            if (fill_done) begin
              fill_cnt <= '0;
              if (mode_sliding) state <= S_RUN;
            end else begin
              fill_cnt <= fill_cnt + FW'(1);
            end
          end
          // Leaving sliding mode: the current bit is the first of a new word.
          S_RUN: begin
            if (!mode_sliding) begin
              fill_cnt <= FW'(1);
              state    <= S_FILL;
            end
          end
          default: state <= state;
        endcase
      end

      if (count_clr) begin
        match_count <= '0;
        count_sat   <= 1'b0;
      end else if (cmp_evt && word_eq) begin
        match_count <= sat_inc(match_count);
        count_sat   <= (sat_inc(match_count) == {CNT_W{1'b1}});
      end
    end
  end

endmodule

// File: tb/tb_serial_word_matcher.sv
// Randomised and directed bench for serial_word_matcher against a queue-based word model.
module tb_serial_word_matcher;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, load_pattern, mode_sliding, bit_valid, bit_in, count_clr;
  logic [W-1:0] pattern_in;

  logic         mv_a, m_a, sat_a, arm_a;
  logic [7:0]   cnt_a;
  logic         mv_b, m_b, sat_b, arm_b;
  logic [1:0]   cnt_b;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int word_q[$];
  int m_pat;
  bit m_armed, m_run;
  int e_valid, e_match, c8, c2;

  always #5 clk = ~clk;

  serial_word_matcher #(.WIDTH(W), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .load_pattern(load_pattern), .pattern_in(pattern_in),
    .mode_sliding(mode_sliding), .bit_valid(bit_valid), .bit_in(bit_in),
    .count_clr(count_clr), .match_valid(mv_a), .match(m_a),
    .match_count(cnt_a), .count_sat(sat_a), .armed(arm_a)
  );

  serial_word_matcher #(.WIDTH(W), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .load_pattern(load_pattern), .pattern_in(pattern_in),
    .mode_sliding(mode_sliding), .bit_valid(bit_valid), .bit_in(bit_in),
    .count_clr(count_clr), .match_valid(mv_b), .match(m_b),
    .match_count(cnt_b), .count_sat(sat_b), .armed(arm_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qval();
    int v = 0;
    foreach (word_q[i]) v = v * 2 + word_q[i];
    return v;
  endfunction

  // Word-level model: collect accepted bits, compare whenever a full word
  // (framed) or a full window (sliding) is available.
  task automatic model_edge(input bit r, lp, input int pin, input bit ms, bv, bi, cc);
    if (r) begin
      word_q.delete();
      m_pat = 0; m_armed = 0; m_run = 0;
      e_valid = 0; e_match = 0; c8 = 0; c2 = 0;
      return;
    end
    e_valid = 0;
    if (lp) begin
      m_pat = pin; word_q.delete(); m_run = 0; m_armed = 1;
    end else if (bv && m_armed) begin
      word_q.push_back(int'(bi));
      if (word_q.size() > W) void'(word_q.pop_front());
      if (m_run && !ms) begin
        m_run = 0;
        word_q.delete();
        word_q.push_back(int'(bi));
      end else if (m_run || word_q.size() == W) begin
        e_valid = 1;
        e_match = (qval() == m_pat) ? 1 : 0;
        if (!m_run) begin
          if (ms) m_run = 1;
          else word_q.delete();
        end
      end
    end
    if (cc) begin
      c8 = 0; c2 = 0;
    end else if (e_valid && e_match) begin
      if (c8 < 255) c8++;
      if (c2 < 3) c2++;
    end
  endtask

  task automatic step(input bit r, lp, input int pin, input bit ms, bv, bi, cc);
    logic [31:0] pv;
    pv = pin;
    rst = r; load_pattern = lp; pattern_in = pv[W-1:0];
    mode_sliding = ms; bit_valid = bv; bit_in = bi; count_clr = cc;
    @(posedge clk);
    model_edge(r, lp, pin, ms, bv, bi, cc);
    #1;
    chk("valid_a", mv_a, e_valid);
    chk("match_a", m_a, e_match);
    chk("count_a", cnt_a, c8);
    chk("sat_a", sat_a, (c8 == 255));
    chk("armed_a", arm_a, m_armed);
    chk("valid_b", mv_b, e_valid);
    chk("match_b", m_b, e_match);
    chk("count_b", cnt_b, c2);
    chk("sat_b", sat_b, (c2 == 3));
    chk("armed_b", arm_b, m_armed);
  endtask

  // Send n bits of val MSB first, each preceded by gap idle cycles.
  task automatic send(input int n, input int val, input bit ms, input int gap);
    logic [31:0] v;
    v = val;
    for (int i = n - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) step(0, 0, 0, ms, 0, 0, 0);
      step(0, 0, 0, ms, 1, v[i], 0);
    end
  endtask

  initial begin
    rst = 1; load_pattern = 0; pattern_in = '0; mode_sliding = 0;
    bit_valid = 0; bit_in = 0; count_clr = 0;

    // 1: reset, unarmed bits are ignored
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    send(8, 8'hB5, 0, 0);
    chk("t1_armed", arm_a, 0);
    chk("t1_count", cnt_a, 0);

    // 2: framed match then mismatch
    step(0, 1, 4'b1010, 0, 0, 0, 1);
    send(4, 4'b1010, 0, 0);
    chk("t2_mv", mv_a, 1);
    chk("t2_match", m_a, 1);
    chk("t2_count", cnt_a, 1);
    send(4, 4'b1011, 0, 0);
    chk("t2_miss", m_a, 0);
    chk("t2_count2", cnt_a, 1);

    // 3: sliding window
    step(0, 1, 4'b0110, 1, 0, 0, 1);
    send(7, 7'b0110110, 1, 0);
    chk("t3_match", m_a, 1);
    chk("t3_count", cnt_a, 2);

    // 4: framed with gaps
    step(0, 1, 4'b1010, 0, 0, 0, 1);
    send(4, 4'b1010, 0, 3);
    chk("t4_match", m_a, 1);
    chk("t4_count", cnt_a, 1);
    send(4, 4'b1011, 0, 3);
    chk("t4_miss", m_a, 0);

    // 5: saturation on CNT_W=2, then clear coinciding with a match
    step(0, 1, 4'b1010, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      send(4, 4'b1010, 0, 0);
      chk("t5_count_b", cnt_b, (k < 3) ? k + 1 : 3);
    end
    chk("t5_sat_b", sat_b, 1);
    send(3, 3'b101, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    chk("t5_clr_mv", mv_b, 1);
    chk("t5_clr_cnt", cnt_b, 0);

    // 6: load collides with a bit, then reset mid-word
    step(0, 1, 4'b0110, 0, 0, 0, 1);
    send(2, 2'b11, 0, 0);
    step(0, 1, 4'b0110, 0, 1, 1, 0);
    send(4, 4'b0110, 0, 0);
    chk("t6_match", m_a, 1);
    send(2, 2'b01, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0);
    chk("t6_armed", arm_a, 0);
    chk("t6_mv", mv_a, 0);

    // 8-bit counter saturation with a sliding all-zero window
    step(0, 1, 4'b0000, 1, 0, 0, 1);
    for (int k = 0; k < 300; k++) step(0, 0, 0, 1, 1, 0, 0);
    chk("sat8_count", cnt_a, 255);
    chk("sat8_flag", sat_a, 1);

    // Randomised traffic
    begin
      bit ms;
      ms = 0;
      step(0, 1, $urandom_range(0, 15), ms, 0, 0, 1);
      for (int k = 0; k < 4000; k++) begin
        bit r, lp, bv, bi, cc;
        int pin;
        r   = ($urandom_range(0, 499) == 0);
        lp  = ($urandom_range(0, 99) == 0);
        cc  = ($urandom_range(0, 149) == 0);
        bv  = ($urandom_range(0, 3) != 0);
        bi  = $urandom_range(0, 1);
        pin = $urandom_range(0, 15);
        if ($urandom_range(0, 29) == 0) ms = ~ms;
        step(r, lp, pin, ms, bv, bi, cc);
        if (r) step(0, 1, pin, ms, 0, 0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
